// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: frame-coherent multiplexed MM.SS 7-segment driver with
// anti-ghost dead time, leading-zero blanking and overflow blink.
module bcd_display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int DEADTIME     = 2,
    parameter int BLINK_FRAMES = 250,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic [3:0] sec_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic       OVERFLOW,
    input  logic       BLANK_LZ,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       FRAME
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic INV = ACTIVE_LOW != 0;
    localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     idx, idx_n;
    logic [3:0][3:0] sh, sh_n;
    logic           sh_ovf, ovf_n, phase, phase_n;
    logic [BW-1:0]  blink_cnt, blink_n, blink_inc;
    logic           wrap, snap, roll, lit;
    logic [3:0]     an_n;
    logic [6:0]     seg_n;
    // Outputs are decoded from the next state so the registered outputs match the state held alongside them.
    always_comb begin
        wrap      = cnt == CW'(REFRESH_DIV - 1);
        snap      = wrap && idx == 2'd3;
        cnt_n     = wrap ? '0 : cnt + CW'(1);
        idx_n     = wrap ? idx + 2'd1 : idx;
        sh_n      = snap ? {min_tens, min_units, sec_tens, sec_units} : sh;
        ovf_n     = snap ? OVERFLOW : sh_ovf;
        blink_inc = blink_cnt + BW'(1);
        roll      = blink_inc == BW'(BLINK_FRAMES);
        blink_n   = !snap ? blink_cnt : (OVERFLOW && sh_ovf && !roll) ? blink_inc : '0;
        phase_n   = !snap ? phase : (!OVERFLOW || (phase ^ (sh_ovf && roll)));
        lit       = phase_n && cnt_n >= CW'(DEADTIME) &&
                    !(idx_n == 2'd3 && BLANK_LZ && sh_n[3] == 4'd0);
        an_n      = lit ? 4'b0001 << idx_n : 4'b0000;
        seg_n     = LUT[sh_n[idx_n]];
    end
    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt       <= '0;
            idx       <= 2'd3;
            sh        <= '0;
            sh_ovf    <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            AN        <= {4{INV}};
            SEG       <= {7{INV}};
            DP        <= INV;
            FRAME     <= 1'b0;
        end else if (CE) begin
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            sh_ovf    <= ovf_n;
            blink_cnt <= blink_n;
            phase     <= phase_n;
            AN        <= an_n ^ {4{INV}};
            SEG       <= seg_n ^ {7{INV}};
            DP        <= an_n[2] ^ INV;
            FRAME     <= snap;
        end else begin
            FRAME     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: elapsed-cycle model of the scanner checked every cycle,
// plus directed literal expectations for scan, tearing, blanking, blink, CE and reset.
module tb_bcd_display_scanner;
    logic       clk = 1'b0;
    logic       CLR, CE, OVERFLOW, BLANK_LZ;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic [6:0] SEG;
    logic       DP, FRAME;
    logic [3:0] AN;
    int checks = 0, failures = 0;

    bcd_display_scanner #(.REFRESH_DIV(4), .DEADTIME(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1)) dut (
        .CLK(clk), .CLR(CLR), .CE(CE), .sec_units(sec_units), .sec_tens(sec_tens),
        .min_units(min_units), .min_tens(min_tens), .OVERFLOW(OVERFLOW), .BLANK_LZ(BLANK_LZ),
        .SEG(SEG), .DP(DP), .AN(AN), .FRAME(FRAME));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic run(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Model: t = enabled cycles since reset; frame n counts consecutive overflow frames.
    logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    bit         valid = 0, dark = 1, movf = 0, blz = 0, fexp = 0;
    int         t = 0, n = 0;
    logic [3:0] md [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    always @(posedge clk) begin
        if (CLR) begin
            valid = 1; dark = 1; t = 0; n = 0; movf = 0; fexp = 0;
            md = '{4'd0, 4'd0, 4'd0, 4'd0};
        end else if (CE) begin
            dark = 0;
            t++;
            fexp = (t % 16 == 4);
            if (fexp) begin
                n = (OVERFLOW && movf) ? n + 1 : 0;
                movf = OVERFLOW;
                md = '{sec_units, sec_tens, min_units, min_tens};
            end
            blz = BLANK_LZ;
        end else begin
            fexp = 0;
        end
    end

    always @(negedge clk) begin : cmp
        int slot, c;
        bit lit;
        logic [3:0] an_on, an_exp;
        logic [6:0] seg_exp;
        logic dp_exp;
        if (valid) begin
            slot = (t / 4 + 3) % 4;
            c = t % 4;
            lit = !movf || ((n / 2) % 2 == 0);
            an_on = (!dark && c >= 1 && lit && !(slot == 3 && blz && md[3] == 4'd0))
                    ? 4'(1 << slot) : 4'd0;
            an_exp = ~an_on;
            seg_exp = dark ? 7'h7F : ~dec[md[slot]];
            dp_exp = ~an_on[2];
            check("model_an", AN, an_exp);
            check("model_seg", SEG, seg_exp);
            check("model_dp", DP, dp_exp);
            check("model_frame", FRAME, fexp);
        end
    end

    initial begin
        CLR = 1; CE = 1; OVERFLOW = 0; BLANK_LZ = 0;
        min_tens = 1; min_units = 2; sec_tens = 3; sec_units = 5;
        run(3);
        check("rst_an", AN, 4'hF); check("rst_seg", SEG, 7'h7F);
        check("rst_dp", DP, 1'b1); check("rst_frame", FRAME, 1'b0);
        CLR = 0;
        run(3);  check("frame_t3", FRAME, 1'b0);
        run(1);  check("frame_t4", FRAME, 1'b1); check("dead_an", AN, 4'hF); check("dead_seg", SEG, 7'h12);
        run(1);  check("s0_an", AN, 4'hE); check("s0_seg", SEG, 7'h12); check("s0_dp", DP, 1'b1);
        run(4);  check("s1_an", AN, 4'hD); check("s1_seg", SEG, 7'h30);
        run(4);  check("s2_an", AN, 4'hB); check("s2_seg", SEG, 7'h24); check("s2_dp", DP, 1'b0);
        sec_units = 9;
        run(4);  check("s3_an", AN, 4'h7); check("s3_seg", SEG, 7'h79); check("s3_dp", DP, 1'b1);
        run(3);  check("frame_t20", FRAME, 1'b1); check("tear_seg", SEG, 7'h10);
        run(1);  check("tear_an", AN, 4'hE);
        min_tens = 0; BLANK_LZ = 1; sec_units = 4'hB;
        run(16); check("dash_an", AN, 4'hE); check("dash_seg", SEG, 7'h3F);
        run(12); check("lz_blank_an", AN, 4'hF); check("lz_blank_seg", SEG, 7'h40);
        BLANK_LZ = 0;
        run(1);  check("lz_show_an", AN, 4'h7); check("lz_show_seg", SEG, 7'h40);
        OVERFLOW = 1;
        run(3);  check("blink_f0", AN, 4'hE);
        run(16); check("blink_f1", AN, 4'hE);
        run(16); check("blink_f2", AN, 4'hF);
        OVERFLOW = 0;
        run(16); check("blink_clear", AN, 4'hE);
        OVERFLOW = 1;
        run(32); check("blink_restart_f1", AN, 4'hE);
        run(16); check("blink_restart_f2", AN, 4'hF);
        OVERFLOW = 0;
        run(17); check("pre_ce_an", AN, 4'hE); check("pre_ce_seg", SEG, 7'h3F);
        CE = 0;
        run(10); check("ce_an", AN, 4'hE); check("ce_seg", SEG, 7'h3F); check("ce_frame", FRAME, 1'b0);
        CE = 1;
        run(1);  check("ce_resume_an", AN, 4'hE);
        run(13); check("ce_frame_timing", FRAME, 1'b1);
        run(6);
        CLR = 1;
        run(1);  check("rst2_an", AN, 4'hF); check("rst2_seg", SEG, 7'h7F);
        check("rst2_dp", DP, 1'b1); check("rst2_frame", FRAME, 1'b0);
        CLR = 0;
        run(4);  check("rst2_first_frame", FRAME, 1'b1);
        run(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
